// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared FSM state type, master IDs and default widths
// for the data-memory arbiter.
package dmem_arb_pkg;
   typedef enum logic [1:0] {IDLE, CPU_RD, DMA_RD} state_e;
   localparam logic MST_CPU = 1'b0;
   localparam logic MST_DMA = 1'b1;
   localparam int unsigned DEF_ADDR_W = 32;
   localparam int unsigned DEF_DATA_W = 32;
endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: combinational two-way picker; prio_i names the master
// that wins when both request.
module dmem_arb_pick
   import dmem_arb_pkg::*;
(
   input  logic cpu_req_i,
   input  logic dma_req_i,
   input  logic prio_i,
   output logic cpu_gnt_o,
   output logic dma_gnt_o
);
   assign cpu_gnt_o = cpu_req_i & (!dma_req_i | (prio_i == MST_CPU));
   assign dma_gnt_o = dma_req_i & (!cpu_req_i | (prio_i == MST_DMA));
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the CPU Mem stage and a DMA master.
// Define DMEM_ARB_RR_EN for round-robin on contended grants; default is fixed CPU priority.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [DATA_W-1:0] cpu_wdata_i,
   output logic              cpu_stall_o,
   output logic              cpu_rvalid_o,
   output logic [DATA_W-1:0] cpu_rdata_o,
   input  logic              dma_req_i,
   input  logic              dma_we_i,
   input  logic [ADDR_W-1:0] dma_addr_i,
   input  logic [DATA_W-1:0] dma_wdata_i,
   output logic              dma_gnt_o,
   output logic              dma_rvalid_o,
   output logic [DATA_W-1:0] dma_rdata_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i
);
   state_e state_q, state_d;
   logic   idle, cpu_gnt, dma_gnt, prio;
   // Reset masks every output so a read pending at reset is silently dropped.
   assign idle = rst_i & (state_q == IDLE);
`ifdef DMEM_ARB_RR_EN
   logic prio_q, prio_d;
   assign prio   = prio_q;
   assign prio_d = (cpu_gnt | dma_gnt) & cpu_req_i & dma_req_i ? (cpu_gnt ? MST_DMA : MST_CPU) : prio_q;
`else
   assign prio = MST_CPU;
`endif
   dmem_arb_pick u_pick (
      .cpu_req_i (cpu_req_i & idle),
      .dma_req_i (dma_req_i & idle),
      .prio_i    (prio),
      .cpu_gnt_o (cpu_gnt),
      .dma_gnt_o (dma_gnt)
   );
   always_comb begin
      state_d      = (cpu_gnt & !cpu_we_i) ? CPU_RD : (dma_gnt & !dma_we_i) ? DMA_RD : IDLE;
      mem_en_o     = cpu_gnt | dma_gnt;
      mem_we_o     = cpu_gnt ? cpu_we_i : dma_gnt & dma_we_i;
      mem_addr_o   = cpu_gnt ? cpu_addr_i : dma_gnt ? dma_addr_i : '0;
      mem_wdata_o  = cpu_gnt ? cpu_wdata_i : dma_gnt ? dma_wdata_i : '0;
      dma_gnt_o    = dma_gnt;
      cpu_rvalid_o = rst_i & (state_q == CPU_RD);
      dma_rvalid_o = rst_i & (state_q == DMA_RD);
      cpu_rdata_o  = cpu_rvalid_o ? mem_rdata_i : '0;
      dma_rdata_o  = dma_rvalid_o ? mem_rdata_i : '0;
      cpu_stall_o  = idle ? cpu_req_i & (!cpu_gnt | !cpu_we_i) : dma_rvalid_o & cpu_req_i;
   end
   always_ff @(posedge clk_i) begin
      state_q <= rst_i ? state_d : IDLE;
`ifdef DMEM_ARB_RR_EN
      prio_q  <= rst_i ? prio_d : MST_CPU;
`endif
   end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, byte address width of all address ports.
REQ-002 Parameter: DATA_W, 32, data width of all data ports.
REQ-003 Port: clk  input  1  single clock; all state updates on posedge.
REQ-004 Port: rst  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-005 Port: cpu_req, cpu_we  input  1 each  Mem-stage access request / write enable (MemWriteM).
REQ-006 Port: cpu_addr, cpu_wdata  input  ADDR_W / DATA_W  Mem-stage address (ALU_ResultM) / store data (WriteDataM).
REQ-007 Port: cpu_stall  output  1  holds the pipeline front end and the Mem stage.
REQ-008 Port: cpu_rvalid, cpu_rdata  output  1 / DATA_W  CPU load data valid / load data.
REQ-009 Port: dma_req, dma_we  input  1 each  secondary-master request / write enable.
REQ-010 Port: dma_addr, dma_wdata  input  ADDR_W / DATA_W  secondary-master address / write data.
REQ-011 Port: dma_gnt  output  1  request accepted this cycle.
REQ-012 Port: dma_rvalid, dma_rdata  output  1 / DATA_W  secondary-master read data valid / read data.
REQ-013 Port: mem_en, mem_we  output  1 each  data memory access strobe / write enable.
REQ-014 Port: mem_addr, mem_wdata  output  ADDR_W / DATA_W  data memory address / write data.
REQ-015 Port: mem_rdata  input  DATA_W  data memory read data, valid the cycle after a read strobe.

Function
REQ-016 FSM states: IDLE, CPU_RD, DMA_RD; the block issues at most one memory access per cycle.
REQ-017 New grants are issued only in IDLE; in CPU_RD and DMA_RD, mem_en = 0.
REQ-018 Default priority in IDLE: CPU request beats simultaneous DMA request.
REQ-019 Granted access: mem_en = 1 with the winner's we/addr/wdata driven combinationally in the grant cycle; the loser's mem_* values are never driven.
REQ-020 Write grant completes in the grant cycle; the FSM stays in IDLE.
REQ-021 Read grant moves the FSM to CPU_RD or DMA_RD; the next cycle asserts the owner's rvalid with rdata = mem_rdata, then returns to IDLE.
REQ-022 cpu_stall timing: in IDLE, cpu_stall = cpu_req AND (CPU not granted OR cpu_we = 0); in CPU_RD, cpu_stall = 0; in DMA_RD, cpu_stall = cpu_req.
REQ-023 Read latency: CPU load = 2 cycles (grant, data), no contention; CPU store = 1 cycle, zero stall cycles.
REQ-024 dma_gnt is a single-cycle pulse per accepted request; the DMA master holds req/addr/wdata stable until gnt.
REQ-025 cpu_rdata and dma_rdata equal mem_rdata when the respective rvalid = 1; otherwise they are 0.
REQ-026 Back-to-back: after any read completes, the FSM arbitrates again on the following cycle; continuous CPU loads yield one grant every 2 cycles.
REQ-027 When neither master is requesting, all mem_* outputs, gnt and rvalid outputs are 0.

Reset
REQ-028 While rst = 0 at posedge clk: FSM → IDLE, round-robin pointer → CPU-preferred, all registered outputs → 0.
REQ-029 Reset asserted during CPU_RD or DMA_RD discards the pending read; no rvalid follows reset.
REQ-030 The first grant is possible in the first cycle after rst returns high.

Configuration
REQ-031 Macro: DMEM_ARB_RR_EN. When defined, IDLE arbitration is round-robin: the master that lost the last contended grant wins the next contended grant, and the pointer updates only on contended grants.
REQ-032 When DMEM_ARB_RR_EN is undefined, arbitration is fixed CPU priority and no pointer register exists.

Structure
REQ-033 Package dmem_arb_pkg: FSM state enum (IDLE, CPU_RD, DMA_RD), master-ID constants (MST_CPU = 0, MST_DMA = 1), default widths.
REQ-034 One sub-module, dmem_arb_pick: combinational 2-way picker with an optional priority-pointer input; the FSM and output muxing live in dmem_arbiter.

Verification
REQ-035 CPU load only, addr 0x10, mem holds 0xDEADBEEF → mem_en at T0, cpu_stall = 1 at T0, cpu_rvalid = 1 with cpu_rdata = 0xDEADBEEF and cpu_stall = 0 at T1.
REQ-036 CPU store 0x55 to 0x20 together with DMA read of 0x20 → CPU granted at T0 with cpu_stall = 0; dma_gnt at T1; dma_rvalid at T2 with data 0x55.
REQ-037 DMA read 0x40 in flight (DMA_RD) while CPU load arrives → cpu_stall = 1 for 2 cycles, CPU granted in the cycle after dma_rvalid.
REQ-038 Both masters issue continuous writes for 6 cycles → without DMEM_ARB_RR_EN: 6 CPU grants, 0 dma_gnt; with DMEM_ARB_RR_EN: grants alternate CPU, DMA, CPU, ...
REQ-039 rst driven low in the CPU_RD cycle → no cpu_rvalid afterwards, FSM IDLE, all outputs 0 the following cycle.
REQ-040 No requests for 5 cycles → mem_en, dma_gnt, cpu_rvalid, dma_rvalid, cpu_stall all remain 0.
